// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared defaults and helpers for the fetch queue unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int PC_STEP      = 1;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous FIFO with push/pop/flush and occupancy count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o
);

  localparam int                PTR_W    = clog2(DEPTH);
  localparam int                CNT_W    = clog2(DEPTH+1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// ============================================================================
//  Module   : fetch_queue_unit
//  Purpose  : Credit-limited instruction fetch with prefetch queue and redirect.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_ir_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [ADDR_W-1:0] fetch_pc_o
);

  localparam int CNT_W  = clog2(DEPTH+1);
  // Stale responses from several quick redirects can pile up before they return.
  localparam int DROP_W = CNT_W + 2;

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [DROP_W-1:0]        drop_q, drop_d;
  logic [CNT_W-1:0]         w_outstanding;
  logic [CNT_W-1:0]         w_q_count;
  logic                     w_tag_full, w_tag_empty;
  logic                     w_q_full, w_q_empty;
  logic [ADDR_W-1:0]        w_tag_pc;
  logic [ADDR_W+DATA_W-1:0] w_q_head;
  logic                     w_credit;
  logic                     w_req_fire;
  logic                     w_rsp_keep;
  logic                     w_out_pop;

  assign w_credit        = ({1'b0, w_outstanding} + {1'b0, w_q_count}) < (CNT_W+1)'(DEPTH);
  assign mem_req_valid_o = !rst && !redirect_valid_i && w_credit;
  assign w_req_fire      = mem_req_valid_o && mem_req_ready_i;
  assign w_rsp_keep      = mem_rsp_valid_i && !redirect_valid_i && (drop_q == '0);
  assign w_out_pop       = out_valid_o && out_ready_i;

  assign mem_req_addr_o  = fetch_pc_q;
  assign fetch_pc_o      = fetch_pc_q;
  assign out_valid_o     = !w_q_empty;
  assign {out_pc_o, out_ir_o} = w_q_head;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      // Everything in flight becomes stale; a response landing now is already one of them.
      drop_d     = drop_q + DROP_W'(w_outstanding) - DROP_W'(mem_rsp_valid_i);
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (mem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Tag FIFO occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (w_req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (w_rsp_keep),
    .data_o  (w_tag_pc),
    .full_o  (w_tag_full),
    .empty_o (w_tag_empty),
    .count_o (w_outstanding)
  );

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (w_rsp_keep),
    .data_i  ({w_tag_pc, mem_rsp_data_i}),
    .pop_i   (w_out_pop),
    .data_o  (w_q_head),
    .full_o  (w_q_full),
    .empty_o (w_q_empty),
    .count_o (w_q_count)
  );

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_req_fire && w_tag_full && !w_rsp_keep));
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_rsp_keep && w_q_full && !w_out_pop));
  a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
    !(w_rsp_keep && w_tag_empty));

endmodule

`default_nettype wire
